// File: rtl/fp_operand_entry.sv
// Front-panel entry of two short floating-point operands using two debounced buttons
// and two switches; the buttons move a field pointer and step the selected field.

module fp_db_fsm #(
   parameter int unsigned CNT_W = 19
) (
   input  logic clk,
   input  logic reset,
   input  logic in_s,
   output logic tick_c
);

   typedef enum logic [1:0] {
      ST_ZERO  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_ONE   = 2'd2,
      ST_WAIT0 = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_ZERO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A level is accepted once the counter has run through its full range without a flip.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_c  = 1'b0;
      case (state_q)
         ST_ZERO: begin
            if (in_s) begin
               state_d = ST_WAIT1;
               cnt_d   = '0;
            end
         end
         ST_WAIT1: begin
            if (!in_s) begin
               state_d = ST_ZERO;
            end else if (cnt_q == '1) begin
               state_d = ST_ONE;
               tick_c  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ONE: begin
            if (!in_s) begin
               state_d = ST_WAIT0;
               cnt_d   = '0;
            end
         end
         ST_WAIT0: begin
            if (in_s) begin
               state_d = ST_ONE;
            end else if (cnt_q == '1) begin
               state_d = ST_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_ZERO;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

module fp_operand_entry #(
   parameter int unsigned DB_CNT_W = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] btn,
   input  logic [1:0] sw,
   output logic       sign1,
   output logic       sign2,
   output logic [3:0] exp1,
   output logic [3:0] exp2,
   output logic [7:0] frac1,
   output logic [7:0] frac2,
   output logic       edit_op,
   output logic [1:0] edit_field
);

   localparam int unsigned NUM_OPS = 2;
   localparam int unsigned EXP_W   = 4;
   localparam int unsigned FRAC_W  = 7;

   localparam logic [1:0] F_SIGN    = 2'd0;
   localparam logic [1:0] F_EXP     = 2'd1;
   localparam logic [1:0] F_FRAC_HI = 2'd2;
   localparam logic [1:0] F_FRAC_LO = 2'd3;

   logic [1:0] btn_s1_q, btn_s2_q;
   logic [1:0] sw_s1_q, sw_s2_q;
   logic [1:0] tick_c;

   logic                              adv_tick_c, step_tick_c;
   logic                              op_sel, dir_down;
   logic [1:0]                        field_q, field_d;
   logic [NUM_OPS-1:0]                sign_q, sign_d;
   logic [NUM_OPS-1:0][EXP_W-1:0]     exp_q, exp_d;
   logic [NUM_OPS-1:0][FRAC_W-1:0]    frac_q, frac_d;

   // Two-flop synchronizers for every raw button and switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn;
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_db
      fp_db_fsm #(
         .CNT_W (DB_CNT_W)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .in_s   (btn_s2_q[i]),
         .tick_c (tick_c[i])
      );
   end

   assign adv_tick_c  = tick_c[0];
   assign step_tick_c = tick_c[1];
   assign op_sel      = sw_s2_q[0];
   assign dir_down    = sw_s2_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         field_q <= F_SIGN;
         sign_q  <= '0;
         exp_q   <= '0;
         frac_q  <= '0;
      end else begin
         field_q <= field_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         frac_q  <= frac_d;
      end
   end

   // Advance wins over step when both ticks land in the same cycle.
   always_comb begin
      field_d = field_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      frac_d  = frac_q;
      if (adv_tick_c) begin
         field_d = field_q + 2'd1;
      end else if (step_tick_c) begin
         case (field_q)
            F_SIGN: begin
               sign_d[op_sel] = ~sign_q[op_sel];
            end
            F_EXP: begin
               exp_d[op_sel] = exp_q[op_sel] + (dir_down ? 4'hF : 4'h1);
            end
            F_FRAC_HI: begin
               frac_d[op_sel][6:4] = frac_q[op_sel][6:4] + (dir_down ? 3'd7 : 3'd1);
            end
            F_FRAC_LO: begin
               frac_d[op_sel][3:0] = frac_q[op_sel][3:0] + (dir_down ? 4'hF : 4'h1);
            end
            default: begin
               field_d = F_SIGN;
            end
         endcase
      end
   end

   // The hidden leading fraction bit is not stored.
   assign sign1      = sign_q[0];
   assign sign2      = sign_q[1];
   assign exp1       = exp_q[0];
   assign exp2       = exp_q[1];
   assign frac1      = {1'b1, frac_q[0]};
   assign frac2      = {1'b1, frac_q[1]};
   assign edit_op    = sw_s2_q[0];
   assign edit_field = field_q;

endmodule

// File: tb/tb_fp_operand_entry.sv
// Randomized and directed bench for fp_operand_entry with a run-length debounce model.

module tb_fp_operand_entry;

   localparam int unsigned DB     = 4;
   localparam int          PERIOD = (1 << DB) + 1;

   logic       clk;
   logic       reset;
   logic [1:0] btn;
   logic [1:0] sw;
   logic       sign1, sign2;
   logic [3:0] exp1, exp2;
   logic [7:0] frac1, frac2;
   logic       edit_op;
   logic [1:0] edit_field;

   int n_checks = 0;
   int n_fail   = 0;

   fp_operand_entry #(.DB_CNT_W(DB)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .sw         (sw),
      .sign1      (sign1),
      .sign2      (sign2),
      .exp1       (exp1),
      .exp2       (exp2),
      .frac1      (frac1),
      .frac2      (frac2),
      .edit_op    (edit_op),
      .edit_field (edit_field)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: raw inputs delayed two clocks; a button level is accepted after
   // PERIOD consecutive delayed samples differing from the accepted level.
   bit [1:0] m_bs1 = '0, m_bs2 = '0, m_ss1 = '0, m_ss2 = '0;
   bit       m_acc [2];
   int       m_run [2];
   int       m_sign [2], m_exp [2], m_fhi [2], m_flo [2];
   int       m_field = 0;

   always @(posedge clk or posedge reset) begin
      bit tk [2];
      int op, dn;
      if (reset) begin
         m_bs1 = '0; m_bs2 = '0; m_ss1 = '0; m_ss2 = '0;
         m_field = 0;
         for (int i = 0; i < 2; i++) begin
            m_acc[i] = 1'b0; m_run[i] = 0;
            m_sign[i] = 0; m_exp[i] = 0; m_fhi[i] = 0; m_flo[i] = 0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            tk[b] = 1'b0;
            if (m_bs2[b] != m_acc[b]) begin
               m_run[b]++;
               if (m_run[b] == PERIOD) begin
                  m_acc[b] = m_bs2[b];
                  m_run[b] = 0;
                  tk[b]    = m_acc[b];
               end
            end else begin
               m_run[b] = 0;
            end
         end
         op = int'(m_ss2[0]);
         dn = int'(m_ss2[1]);
         if (tk[0]) begin
            m_field = (m_field + 1) % 4;
         end else if (tk[1]) begin
            case (m_field)
               0: m_sign[op] = 1 - m_sign[op];
               1: m_exp[op]  = (m_exp[op] + (dn ? 15 : 1)) % 16;
               2: m_fhi[op]  = (m_fhi[op] + (dn ? 7 : 1)) % 8;
               default: m_flo[op] = (m_flo[op] + (dn ? 15 : 1)) % 16;
            endcase
         end
         m_bs2 = m_bs1; m_bs1 = btn;
         m_ss2 = m_ss1; m_ss1 = sw;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (!reset) begin
         chk("sign1", 32'(sign1), 32'(m_sign[0]));
         chk("sign2", 32'(sign2), 32'(m_sign[1]));
         chk("exp1", 32'(exp1), 32'(m_exp[0]));
         chk("exp2", 32'(exp2), 32'(m_exp[1]));
         chk("frac1", 32'(frac1), 32'(128 + 16 * m_fhi[0] + m_flo[0]));
         chk("frac2", 32'(frac2), 32'(128 + 16 * m_fhi[1] + m_flo[1]));
         chk("edit_op", 32'(edit_op), 32'(m_ss2[0]));
         chk("edit_field", 32'(edit_field), 32'(m_field));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int b, input int hold);
      @(negedge clk);
      btn[b] = 1'b1;
      cycles(hold);
      btn[b] = 1'b0;
      cycles(24);
   endtask

   initial begin
      int lat;
      int hold;
      reset = 1'b1;
      btn   = '0;
      sw    = '0;
      cycles(3);
      reset = 1'b0;

      // Idle after reset.
      cycles(100);
      chk("rst_sign1", 32'(sign1), 32'h0);
      chk("rst_exp2", 32'(exp2), 32'h0);
      chk("rst_frac1", 32'(frac1), 32'h80);
      chk("rst_frac2", 32'(frac2), 32'h80);
      chk("rst_field", 32'(edit_field), 32'h0);
      chk("rst_op", 32'(edit_op), 32'h0);

      // Short glitch is rejected.
      btn[1] = 1'b1;
      cycles(5);
      btn[1] = 1'b0;
      cycles(30);
      chk("glitch_sign1", 32'(sign1), 32'h0);

      // Held press toggles sign1 once, 19 cycles after press.
      btn[1] = 1'b1;
      lat = 0;
      while (sign1 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("press_latency", 32'(lat), 32'd19);
      cycles(40 - lat);
      btn[1] = 1'b0;
      cycles(25);
      chk("held_sign1", 32'(sign1), 32'h1);

      // Exponent wraps upward then downward.
      press(0, 20);
      chk("field_exp", 32'(edit_field), 32'h1);
      for (int i = 0; i < 17; i++) press(1, 20);
      chk("exp1_up17", 32'(exp1), 32'h1);
      sw[1] = 1'b1;
      press(1, 20);
      press(1, 20);
      chk("exp1_down2", 32'(exp1), 32'hF);

      // Operand 2, FRAC_LO step down, then pointer wrap.
      sw = 2'b11;
      press(0, 20);
      press(0, 20);
      chk("field_fraclo", 32'(edit_field), 32'h3);
      press(1, 20);
      chk("frac2_down", 32'(frac2), 32'h8F);
      chk("frac1_hold", 32'(frac1), 32'h80);
      press(0, 20);
      chk("field_wrap", 32'(edit_field), 32'h0);

      // Simultaneous advance and step: step discarded.
      @(negedge clk);
      btn = 2'b11;
      cycles(40);
      btn = 2'b00;
      cycles(25);
      chk("both_field", 32'(edit_field), 32'h1);
      chk("both_sign2", 32'(sign2), 32'h0);
      chk("both_exp2", 32'(exp2), 32'h0);

      // Reset during a pending press discards it.
      @(negedge clk);
      btn[1] = 1'b1;
      cycles(8);
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(5);
      btn[1] = 1'b0;
      cycles(25);
      chk("rstmid_sign2", 32'(sign2), 32'h0);
      chk("rstmid_sign1", 32'(sign1), 32'h0);
      press(1, 20);
      chk("repress_sign2", 32'(sign2), 32'h1);

      // Randomized button/switch activity with occasional resets.
      for (int s = 0; s < 300; s++) begin
         @(negedge clk);
         if ($urandom_range(0, 59) == 0) begin
            reset = 1'b1;
            cycles($urandom_range(1, 3));
            reset = 1'b0;
         end
         btn  = 2'($urandom_range(0, 3));
         sw   = 2'($urandom_range(0, 3));
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10))
                                            : int'($urandom_range(15, 40));
         cycles(hold);
         if ($urandom_range(0, 1) == 0) begin
            btn = '0;
            cycles($urandom_range(1, 30));
         end
      end
      btn = '0;
      cycles(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
